// File: rtl/bus_rr_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
// Widths are capped at 16 drivers and a 16-bit destination field.
package bus_rr_sched_pkg;

    localparam int MAX_DRVRS = 16;
    localparam int MAX_ID_W  = 16;

    localparam int          ID_W_DEF      = 8;
    localparam logic [7:0]  BROADCAST_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_DRVRS-1:0] mask;
        logic                 drop;
    } dest_t;

    // Broadcast goes to every driver but the source; unknown IDs are dropped.
    function automatic dest_t dest_decode(input logic [MAX_ID_W-1:0] dest,
                                          input logic [MAX_ID_W-1:0] bcast,
                                          input int                  drvrs,
                                          input int                  src);
        dest_t res;
        res = '0;
        if (dest == bcast) begin
            for (int i = 0; i < MAX_DRVRS; i++)
                if (i < drvrs && i != src) res.mask[i] = 1'b1;
        end else if (32'(dest) < drvrs) begin
            res.mask[dest[3:0]] = 1'b1;
        end else begin
            res.drop = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_rr_sched_rr_pick.sv
// Combinational round-robin picker: first requester above 'last', with wrap.
module rr_pick #(
    parameter int DRVRS = 4
) (
    input  logic [DRVRS-1:0]         req,
    input  logic [$clog2(DRVRS)-1:0] last,
    output logic [$clog2(DRVRS)-1:0] gnt_id,
    output logic                     any_req
);
    localparam int GW = $clog2(DRVRS);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt_id = '0;
        for (int off = DRVRS; off >= 1; off--) begin
            // Scanning downward lets the nearest requester win by overwriting.
            if (req[(int'(last) + off) % DRVRS])
                gnt_id = GW'((int'(last) + off) % DRVRS);
        end
        any_req = |req;
    end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin transfer scheduler for the shared packet bus (IDLE -> POP -> PUSH).
// Define BUS_RR_SCHED_STATS_EN to build the pkt_cnt/drop_cnt statistics counters.
module bus_rr_sched
    import bus_rr_sched_pkg::*;
#(
    parameter int                DRVRS     = 4,
    parameter int                PCKG_SZ   = 16,
    parameter int                ID_W      = ID_W_DEF,
    parameter logic [ID_W-1:0]   BROADCAST = ID_W'(BROADCAST_DEF)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         D_push,
    output logic                       busy,
    output logic [$clog2(DRVRS)-1:0]   grant_id,
    output logic                       drop_err,
    output logic [31:0]                pkt_cnt,
    output logic [15:0]                drop_cnt
);
    localparam int GW = $clog2(DRVRS);

    state_t             state;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      pick_id;
    logic               any_req;
    logic [PCKG_SZ-1:0] head;
    dest_t              dec;
    logic               unused_mask;

    rr_pick #(.DRVRS(DRVRS)) u_pick (
        .req     (pndng),
        .last    (last_grant),
        .gnt_id  (pick_id),
        .any_req (any_req)
    );

    always_comb begin
        head = D_pop[int'(grant_id)*PCKG_SZ +: PCKG_SZ];
        dec  = dest_decode(MAX_ID_W'(head[PCKG_SZ-1 -: ID_W]), MAX_ID_W'(BROADCAST),
                           DRVRS, int'(grant_id));
    end

    assign unused_mask = ^dec.mask;

    always_ff @(posedge clk) begin
        // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            pop        <= '0;
            push       <= '0;
            D_push     <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
            drop_err   <= 1'b0;
            last_grant <= GW'(DRVRS - 1);
        end else begin
            case (state)
                IDLE: begin
                    push     <= '0;
                    drop_err <= 1'b0;
                    if (any_req) begin
                        grant_id <= pick_id;
                        pop      <= DRVRS'(1) << pick_id;
                        busy     <= 1'b1;
                        state    <= POP;
                    end
                end
                POP: begin
                    // The head word is captured on the same edge that ends the pop strobe.
                    pop      <= '0;
                    D_push   <= head;
                    push     <= dec.mask[DRVRS-1:0];
                    drop_err <= dec.drop;
                    state    <= PUSH;
                end
                PUSH: begin
                    push       <= '0;
                    drop_err   <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= grant_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BUS_RR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (state == PUSH) begin
            if (push != '0)                       pkt_cnt  <= pkt_cnt + 32'd1;
            if (drop_err && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_rr_sched.sv
// Randomised self-checking bench for bus_rr_sched against a transaction-schedule model.
module tb_bus_rr_sched;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  pndng = '0;
    logic [N*16-1:0] D_pop = '0;
    logic [N-1:0]  pop, push;
    logic [15:0]   D_push;
    logic          busy, drop_err;
    logic [1:0]    grant_id;
    logic [31:0]   pkt_cnt;
    logic [15:0]   drop_cnt;

    bus_rr_sched dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .grant_id (grant_id),
        .drop_err (drop_err),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: a transfer is a grant edge, then a push edge one cycle
    // later, then the bus is free again one cycle after that.
    int          grant_edge = -100;
    int          last_g = N - 1;
    int          g = 0;
    logic [3:0]  e_pop = '0, e_push = '0, p_mask = '0;
    logic [15:0] e_dpush = '0;
    logic        e_busy = 1'b0, e_drop = 1'b0, p_drop = 1'b0;
    logic [1:0]  e_gid = '0;
    logic [31:0] e_pkt = '0;
    logic [15:0] e_dropc = '0;

    function automatic int rr_next(input logic [3:0] req, input int last);
        for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_edge();
        logic [15:0] word;
        logic [7:0]  dest;
        if (reset) begin
            e_pop = '0; e_push = '0; e_dpush = '0; e_busy = 1'b0; e_gid = '0; e_drop = 1'b0;
            e_pkt = '0; e_dropc = '0;
            grant_edge = -100; last_g = N - 1;
        end else begin
            e_pop = '0; e_push = '0; e_drop = 1'b0;
            if (cyc == grant_edge + 1) begin
                word = D_pop[g*16 +: 16];
                dest = word[15:8];
                if (dest == 8'hFF)   e_push = 4'hF & ~(4'd1 << g);
                else if (dest < N)   e_push = 4'd1 << dest;
                else                 e_drop = 1'b1;
                e_dpush = word;
                e_busy  = 1'b1;
                p_mask  = e_push;
                p_drop  = e_drop;
            end else if (cyc == grant_edge + 2) begin
                e_busy = 1'b0;
`ifdef BUS_RR_SCHED_STATS_EN
                if (p_mask != 0) e_pkt = e_pkt + 1;
                if (p_drop && e_dropc != 16'hFFFF) e_dropc = e_dropc + 1;
`endif
            end else if (pndng != 0) begin
                g = rr_next(pndng, last_g);
                last_g = g;
                grant_edge = cyc;
                e_pop  = 4'd1 << g;
                e_gid  = 2'(g);
                e_busy = 1'b1;
            end else begin
                e_busy = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] pn, input logic [63:0] dp);
        @(negedge clk);
        reset = r;
        pndng = pn;
        D_pop = dp;
        @(posedge clk);
        model_edge();
        #1;
        check("pop",      32'(pop),      32'(e_pop));
        check("push",     32'(push),     32'(e_push));
        check("D_push",   32'(D_push),   32'(e_dpush));
        check("busy",     32'(busy),     32'(e_busy));
        check("grant_id", 32'(grant_id), 32'(e_gid));
        check("drop_err", 32'(drop_err), 32'(e_drop));
        check("pkt_cnt",  pkt_cnt,       e_pkt);
        check("drop_cnt", 32'(drop_cnt), 32'(e_dropc));
        cyc++;
    endtask

    function automatic logic [15:0] rand_word();
        logic [7:0] dest;
        case ($urandom_range(0, 5))
            0, 1, 2: dest = 8'($urandom_range(0, N - 1));
            3:       dest = 8'hFF;
            default: dest = 8'($urandom_range(N, 254));
        endcase
        return {dest, 8'($urandom)};
    endfunction

    function automatic logic [63:0] rand_bus();
        return {rand_word(), rand_word(), rand_word(), rand_word()};
    endfunction

    int grants[$];

    initial begin
        step(1'b1, 4'h0, '0);
        step(1'b1, 4'h0, '0);

        // Driver 0 sends to driver 2.
        step(1'b0, 4'b0001, 64'h0000_0000_0000_02AB);
        check("t1_pop", 32'(pop), 32'h1);
        step(1'b0, 4'b0000, 64'h0000_0000_0000_02AB);
        check("t1_push", 32'(push), 32'h4);
        check("t1_data", 32'(D_push), 32'h02AB);
        step(1'b0, 4'b0000, '0);

        // Driver 1 broadcasts.
        step(1'b0, 4'b0010, 64'h0000_0000_FF55_0000);
        step(1'b0, 4'b0000, 64'h0000_0000_FF55_0000);
        check("t2_push", 32'(push), 32'hD);
        check("t2_drop", 32'(drop_err), 32'h0);
        step(1'b0, 4'b0000, '0);

        // All drivers pending for 12 cycles after reset.
        step(1'b1, 4'h0, '0);
        grants.delete();
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'hF, rand_bus());
            if (pop != 0) grants.push_back(int'(grant_id));
        end
        check("t3_ngrants", 32'(grants.size()), 32'd4);
        foreach (grants[i]) check("t3_order", 32'(grants[i]), 32'(i));
        step(1'b0, 4'h0, '0);
        step(1'b0, 4'h0, '0);

        // Driver 2 sends to a nonexistent destination.
        step(1'b1, 4'h0, '0);
        step(1'b0, 4'b0100, 64'h0000_07C3_0000_0000);
        step(1'b0, 4'b0000, 64'h0000_07C3_0000_0000);
        check("t4_push", 32'(push), 32'h0);
        check("t4_drop", 32'(drop_err), 32'h1);
        step(1'b0, 4'b0000, '0);
        check("t4_drop_end", 32'(drop_err), 32'h0);

        // Reset aborts driver 3's transfer.
        step(1'b0, 4'b1000, 64'h0001_0000_0000_0000);
        check("t5_pop", 32'(pop), 32'h8);
        step(1'b1, 4'b1000, '0);
        check("t5_pop_rst", 32'(pop), 32'h0);
        check("t5_busy_rst", 32'(busy), 32'h0);
        step(1'b0, 4'hF, rand_bus());
        check("t5_first", 32'(grant_id), 32'h0);
        step(1'b0, 4'h0, rand_bus());
        step(1'b0, 4'h0, '0);

        // Driver 1 raises its request during driver 0's push cycle.
        step(1'b1, 4'h0, '0);
        step(1'b0, 4'b0001, 64'h0000_0000_0000_0301);
        step(1'b0, 4'b0000, 64'h0000_0000_0000_0301);
        step(1'b0, 4'b0010, 64'h0000_0000_0200_0000);
        check("t6_wait", 32'(pop), 32'h0);
        step(1'b0, 4'b0010, 64'h0000_0000_0200_0000);
        check("t6_pop", 32'(pop), 32'h2);
        step(1'b0, 4'b0000, 64'h0000_0000_0200_0000);
        step(1'b0, 4'b0000, '0);

        // Random traffic with occasional reset.
        for (int k = 0; k < 600; k++)
            step(($urandom_range(0, 60) == 0), 4'($urandom), rand_bus());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
